// File: rtl/spi_xfer_ctrl_pkg.sv
// rtl/spi_xfer_ctrl_pkg.sv - shared types and constants for the SPI transfer sequencer
package spi_xfer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_XFER  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // The master needs a few cycles to pipeline ss; shorter guard intervals are clamped.
    localparam int GUARD_MIN = 4;

    function automatic logic rising(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// rtl/spi_xfer_ctrl_if.sv - host-side command, TX/RX stream and status bundle
interface spi_xfer_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             abort;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] tx_data;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             busy;
    logic             done;
    logic             underrun;

    modport master (
        output cmd_valid, cmd_len, abort, tx_valid, tx_data,
        input  cmd_ready, tx_ready, rx_valid, rx_data, busy, done, underrun
    );

    modport slave (
        input  cmd_valid, cmd_len, abort, tx_valid, tx_data,
        output cmd_ready, tx_ready, rx_valid, rx_data, busy, done, underrun
    );
endinterface

// File: rtl/spi_xfer_ctrl_hold_reg.sv
// rtl/spi_xfer_ctrl_hold_reg.sv - single-word TX holding register between stream and master
module spi_xfer_ctrl_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             fill,
    input  logic [WIDTH-1:0] fill_data,
    input  logic             drain,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    // A fill in the same cycle as a drain wins: the new word replaces the one just taken.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            full <= 1'b0;
        end else if (fill) begin
            full <= 1'b1;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (fill) begin
            data <= fill_data;
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - frames multi-word SPI transactions on one spi_master instance
module spi_xfer_ctrl
    import spi_xfer_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8,
    parameter int GUARD = 8
) (
    input  logic             clk,
    input  logic             rst,
    spi_xfer_ctrl_if.slave   host,
    output logic             spi_reset,
    output logic             ss_n_en,
    output logic             spi_tx_valid,
    output logic [WIDTH-1:0] spi_tx_data,
    input  logic             spi_tx_int,
    input  logic [WIDTH-1:0] spi_rx_data,
    input  logic             spi_rx_int
);

    localparam int GUARD_EFF = (GUARD < GUARD_MIN) ? GUARD_MIN : GUARD;
    localparam int GW        = $clog2(GUARD_EFF + 1);

    state_t           state;
    state_t           state_nx;
    logic [LEN_W-1:0] tx_left;
    logic [LEN_W-1:0] rx_left;
    logic [GW-1:0]    guard_cnt;
    logic             tx_int_q;
    logic             rx_int_q;
    logic             rx_valid_r;
    logic [WIDTH-1:0] rx_data_r;
    logic             done_r;
    logic             spi_reset_r;
    logic             underrun_r;

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;

    logic             tx_rise;
    logic             rx_rise;
    logic             cmd_accept;
    logic             tx_fire;
    logic             rx_take;
    logic             guard_done;
    logic             active;

    assign tx_rise    = rising(spi_tx_int, tx_int_q);
    assign rx_rise    = rising(spi_rx_int, rx_int_q);
    assign active     = (state == ST_PRIME) || (state == ST_XFER);
    assign cmd_accept = (state == ST_IDLE) && host.cmd_valid;
    assign tx_fire    = host.tx_valid && host.tx_ready;
    // A word landing in the same cycle as an abort is dropped along with the rest.
    assign rx_take    = (state == ST_XFER) && rx_rise && !host.abort;
    assign guard_done = (state == ST_STOP) && (guard_cnt == '0);

    spi_xfer_ctrl_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .flush     (state == ST_STOP),
        .fill      (tx_fire),
        .fill_data (host.tx_data),
        .drain     (tx_rise),
        .full      (hold_full),
        .data      (hold_data)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (host.cmd_valid && (host.cmd_len != '0)) state_nx = ST_PRIME;
            end
            ST_PRIME: begin
                if (host.abort)      state_nx = ST_STOP;
                else if (hold_full)  state_nx = ST_XFER;
            end
            ST_XFER: begin
                if (host.abort)                                   state_nx = ST_STOP;
                else if (rx_take && (rx_left == LEN_W'(1)))       state_nx = ST_STOP;
            end
            ST_STOP: begin
                if (guard_cnt == '0) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            tx_left     <= '0;
            rx_left     <= '0;
            guard_cnt   <= '0;
            tx_int_q    <= 1'b0;
            rx_int_q    <= 1'b0;
            rx_valid_r  <= 1'b0;
            rx_data_r   <= '0;
            done_r      <= 1'b0;
            spi_reset_r <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            state       <= state_nx;
            tx_int_q    <= spi_tx_int;
            rx_int_q    <= spi_rx_int;
            rx_valid_r  <= rx_take;
            done_r      <= (cmd_accept && (host.cmd_len == '0)) || guard_done;
            spi_reset_r <= guard_done;

            if (rx_take) begin
                rx_data_r <= spi_rx_data;
            end

            if (cmd_accept) begin
                tx_left    <= host.cmd_len;
                rx_left    <= host.cmd_len;
                underrun_r <= 1'b0;
            end else begin
                if (tx_fire) tx_left <= tx_left - LEN_W'(1);
                if (rx_take) rx_left <= rx_left - LEN_W'(1);
                // The master has already reloaded from an empty holding reg and resends stale data.
                if (rx_take && (rx_left > LEN_W'(1)) && !hold_full) underrun_r <= 1'b1;
            end

            if ((state != ST_STOP) && (state_nx == ST_STOP)) begin
                guard_cnt <= GW'(GUARD_EFF);
            end else if ((state == ST_STOP) && (guard_cnt != '0)) begin
                guard_cnt <= guard_cnt - GW'(1);
            end
        end
    end

    assign host.cmd_ready = (state == ST_IDLE);
    assign host.busy      = (state != ST_IDLE);
    assign host.tx_ready  = active && !hold_full && (tx_left != '0);
    assign host.rx_valid  = rx_valid_r;
    assign host.rx_data   = rx_data_r;
    assign host.done      = done_r;
    assign host.underrun  = underrun_r;

    assign spi_reset      = spi_reset_r;
    assign ss_n_en        = (state == ST_XFER);
    assign spi_tx_valid   = hold_full && (state != ST_STOP);
    assign spi_tx_data    = hold_data;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - directed bench for spi_xfer_ctrl with a loopback SPI master model
module tb_spi_xfer_ctrl;

    localparam int WIDTH    = 8;
    localparam int LEN_W    = 8;
    localparam int GUARD    = 8;
    localparam int WORD_CYC = 64;

    logic             clk;
    logic             rst;
    logic             spi_reset;
    logic             ss_n_en;
    logic             spi_tx_valid;
    logic [WIDTH-1:0] spi_tx_data;
    logic             spi_tx_int;
    logic [WIDTH-1:0] spi_rx_data;
    logic             spi_rx_int;

    spi_xfer_ctrl_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) host ();

    spi_xfer_ctrl #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W),
        .GUARD (GUARD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .host         (host),
        .spi_reset    (spi_reset),
        .ss_n_en      (ss_n_en),
        .spi_tx_valid (spi_tx_valid),
        .spi_tx_data  (spi_tx_data),
        .spi_tx_int   (spi_tx_int),
        .spi_rx_data  (spi_rx_data),
        .spi_rx_int   (spi_rx_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Loopback master: loads a word while ss is enabled, shifts, returns the same word.
    logic       m_busy;
    int         m_cnt;
    logic [7:0] m_shift;
    always @(posedge clk) begin
        if (rst || spi_reset || !ss_n_en) begin
            m_busy     <= 1'b0;
            m_cnt      <= 0;
            spi_tx_int <= 1'b0;
            spi_rx_int <= 1'b0;
            if (rst) begin
                m_shift     <= '0;
                spi_rx_data <= '0;
            end
        end else if (!m_busy) begin
            m_busy     <= 1'b1;
            m_cnt      <= WORD_CYC;
            spi_tx_int <= 1'b1;
            spi_rx_int <= 1'b0;
            if (spi_tx_valid) m_shift <= spi_tx_data;
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == WORD_CYC / 2) spi_tx_int <= 1'b0;
            if (m_cnt == 1) begin
                spi_rx_data <= m_shift;
                spi_rx_int  <= 1'b1;
                m_busy      <= 1'b0;
            end
        end
    end

    logic [7:0] rx_log[$];
    int         done_cnt   = 0;
    int         sreset_cnt = 0;
    int         ss_rises   = 0;
    int         low_run    = 0;
    int         last_gap   = 0;
    logic       ss_prev    = 1'b0;
    always @(negedge clk) begin
        if (host.rx_valid) rx_log.push_back(host.rx_data);
        if (host.done) done_cnt++;
        if (spi_reset) sreset_cnt++;
        if (ss_n_en) begin
            if (!ss_prev) begin
                ss_rises++;
                last_gap = low_run;
            end
            low_run = 0;
        end else begin
            low_run++;
        end
        ss_prev = ss_n_en;
    end

    logic [7:0] tx_q[$];
    logic       tx_fire_q = 1'b0;
    initial begin
        host.tx_valid = 1'b0;
        host.tx_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_fire_q && tx_q.size() > 0) void'(tx_q.pop_front());
            if (tx_q.size() > 0) begin
                host.tx_valid = 1'b1;
                host.tx_data  = tx_q[0];
            end else begin
                host.tx_valid = 1'b0;
            end
            tx_fire_q = host.tx_valid && host.tx_ready;
        end
    end

    task automatic issue_cmd(input logic [LEN_W-1:0] len);
        @(posedge clk);
        #1;
        host.cmd_valid = 1'b1;
        host.cmd_len   = len;
        @(posedge clk);
        #1;
        host.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            failures++;
            $display("FAIL %s_timeout done_cnt=%0d need=%0d", name, done_cnt, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (host.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", host.cmd_ready); end
        checks++; if (host.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", host.busy); end
        checks++; if (host.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", host.done); end
        checks++; if (host.tx_ready !== 1'b0) begin failures++; $display("FAIL reset_tx_ready got=%b exp=0", host.tx_ready); end
        checks++; if (host.underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", host.underrun); end
        checks++; if (ss_n_en !== 1'b0) begin failures++; $display("FAIL reset_ss got=%b exp=0", ss_n_en); end
        checks++; if (spi_tx_valid !== 1'b0) begin failures++; $display("FAIL reset_spi_tx_valid got=%b exp=0", spi_tx_valid); end
        checks++; if (spi_reset !== 1'b0) begin failures++; $display("FAIL reset_spi_reset got=%b exp=0", spi_reset); end
    endtask

    task automatic test_basic();
        logic [7:0] exp_w[3];
        int d0;
        int r0;
        exp_w = '{8'hA5, 8'h3C, 8'hF0};
        rx_log.delete();
        d0 = done_cnt;
        r0 = sreset_cnt;
        tx_q = '{8'hA5, 8'h3C, 8'hF0};
        issue_cmd(8'd3);
        checks++; if (host.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", host.busy); end
        wait_done(d0 + 1, 2000, "basic");
        repeat (4) @(posedge clk);
        #1;
        checks++; if (rx_log.size() != 3) begin failures++; $display("FAIL basic_rx_count got=%0d exp=3", rx_log.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_log.size() <= i || rx_log[i] !== exp_w[i]) begin
                failures++;
                $display("FAIL basic_rx_word%0d got=%h exp=%h", i, (rx_log.size() > i) ? rx_log[i] : 8'hxx, exp_w[i]);
            end
        end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - d0); end
        checks++; if (sreset_cnt - r0 != 1) begin failures++; $display("FAIL basic_spi_reset_count got=%0d exp=1", sreset_cnt - r0); end
        checks++; if (host.underrun !== 1'b0) begin failures++; $display("FAIL basic_underrun got=%b exp=0", host.underrun); end
        checks++; if (host.cmd_ready !== 1'b1) begin failures++; $display("FAIL basic_cmd_ready got=%b exp=1", host.cmd_ready); end
    endtask

    task automatic test_zero_len();
        int s0;
        s0 = ss_rises;
        issue_cmd(8'd0);
        checks++; if (host.done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", host.done); end
        checks++; if (host.busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", host.busy); end
        checks++; if (host.cmd_ready !== 1'b1) begin failures++; $display("FAIL zero_cmd_ready got=%b exp=1", host.cmd_ready); end
        @(posedge clk);
        #1;
        checks++; if (host.done !== 1'b0) begin failures++; $display("FAIL zero_done_width got=%b exp=0", host.done); end
        repeat (10) @(posedge clk);
        #1;
        checks++; if (ss_rises != s0) begin failures++; $display("FAIL zero_ss_rise got=%0d exp=%0d", ss_rises, s0); end
    endtask

    task automatic test_underrun();
        int d0;
        int n;
        rx_log.delete();
        d0 = done_cnt;
        tx_q = '{8'h11};
        issue_cmd(8'd2);
        n = 0;
        while (rx_log.size() < 1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        tx_q.push_back(8'h22);
        wait_done(d0 + 1, 2000, "underrun");
        repeat (4) @(posedge clk);
        #1;
        checks++; if (host.underrun !== 1'b1) begin failures++; $display("FAIL underrun_flag got=%b exp=1", host.underrun); end
        checks++; if (rx_log.size() != 2) begin failures++; $display("FAIL underrun_rx_count got=%0d exp=2", rx_log.size()); end
        checks++;
        if (rx_log.size() < 1 || rx_log[0] !== 8'h11) begin
            failures++;
            $display("FAIL underrun_rx_word0 got=%h exp=11", (rx_log.size() > 0) ? rx_log[0] : 8'hxx);
        end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL underrun_done_count got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_abort();
        int d0;
        int r0;
        int n;
        rx_log.delete();
        d0 = done_cnt;
        r0 = sreset_cnt;
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        issue_cmd(8'd4);
        n = 0;
        while (rx_log.size() < 1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (20) @(posedge clk);
        #1;
        host.abort = 1'b1;
        @(posedge clk);
        #1;
        host.abort = 1'b0;
        checks++; if (ss_n_en !== 1'b0) begin failures++; $display("FAIL abort_ss_drop got=%b exp=0", ss_n_en); end
        wait_done(d0 + 1, 500, "abort");
        repeat (WORD_CYC + 8) @(posedge clk);
        #1;
        checks++; if (rx_log.size() != 1) begin failures++; $display("FAIL abort_rx_count got=%0d exp=1", rx_log.size()); end
        checks++; if (sreset_cnt - r0 != 1) begin failures++; $display("FAIL abort_spi_reset_count got=%0d exp=1", sreset_cnt - r0); end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL abort_done_count got=%0d exp=1", done_cnt - d0); end
        checks++; if (host.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", host.busy); end
        tx_q.delete();
    endtask

    task automatic test_back_to_back();
        int d0;
        int s0;
        rx_log.delete();
        tx_q.delete();
        d0 = done_cnt;
        s0 = ss_rises;
        tx_q = '{8'h5A, 8'hC3};
        issue_cmd(8'd1);
        wait_done(d0 + 1, 1000, "b2b_first");
        issue_cmd(8'd1);
        wait_done(d0 + 2, 1000, "b2b_second");
        repeat (4) @(posedge clk);
        #1;
        checks++; if (ss_rises - s0 != 2) begin failures++; $display("FAIL b2b_frames got=%0d exp=2", ss_rises - s0); end
        checks++; if (last_gap < GUARD) begin failures++; $display("FAIL b2b_guard_gap got=%0d exp>=%0d", last_gap, GUARD); end
        checks++; if (rx_log.size() != 2) begin failures++; $display("FAIL b2b_rx_count got=%0d exp=2", rx_log.size()); end
        checks++;
        if (rx_log.size() < 2 || rx_log[0] !== 8'h5A || rx_log[1] !== 8'hC3) begin
            failures++;
            $display("FAIL b2b_rx_words got=%h,%h exp=5a,c3",
                     (rx_log.size() > 0) ? rx_log[0] : 8'hxx, (rx_log.size() > 1) ? rx_log[1] : 8'hxx);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        int n;
        rx_log.delete();
        tx_q = '{8'h77};
        issue_cmd(8'd1);
        n = 0;
        while (ss_n_en !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (ss_n_en !== 1'b0) begin failures++; $display("FAIL rstmid_ss got=%b exp=0", ss_n_en); end
        checks++; if (host.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", host.busy); end
        checks++; if (spi_tx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_spi_tx_valid got=%b exp=0", spi_tx_valid); end
        checks++; if (host.tx_ready !== 1'b0) begin failures++; $display("FAIL rstmid_tx_ready got=%b exp=0", host.tx_ready); end
        checks++; if (host.rx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_rx_valid got=%b exp=0", host.rx_valid); end
        rst = 1'b0;
        tx_q.delete();
        rx_log.delete();
        d0 = done_cnt;
        tx_q = '{8'h99};
        issue_cmd(8'd1);
        wait_done(d0 + 1, 1000, "rstmid_after");
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (rx_log.size() != 1 || rx_log[0] !== 8'h99) begin
            failures++;
            $display("FAIL rstmid_after_rx got_n=%0d got=%h exp=99", rx_log.size(), (rx_log.size() > 0) ? rx_log[0] : 8'hxx);
        end
    endtask

    initial begin
        rst            = 1'b1;
        host.cmd_valid = 1'b0;
        host.cmd_len   = '0;
        host.abort     = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_underrun();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
